// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and GF(2^8) helpers for the AES-128 inverse cipher.
//   - RCON[1..10] round constants and a bounded lookup helper
//   - xtime and the fixed multipliers 9/11/13/14 over GF(2^8), poly 0x11B
//   - InvShiftRows / InvMixColumns on a 128-bit state
//     (byte 0 = bits [127:120]; byte 4*c+r is row r of column c)
//   - FSM state enum for the decrypt core
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        KEXP,
        ROUND,
        DONE
    } state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Returns 0 for indices outside 1..10 so a stray counter value can
    // never index past the table.
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (idx == 4'(i)) r = RCON[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] a);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(a)));
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] a);
        logic [7:0] x2, x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] a);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Row r is rotated right by r positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
            };
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: inverse AES S-box. Pure combinational lookup; each row
// constant holds the 16 outputs for one high nibble, leftmost = low nibble 0.
// Ports: a_i (byte in), y_o (inverse-substituted byte out).
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    logic [127:0] row;

    always_comb begin
        case (a_i[7:4])
            4'h0:    row = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;
            4'h1:    row = 128'h7ce33982_9b2fff87_348e4344_c4dee9cb;
            4'h2:    row = 128'h547b9432_a6c2233d_ee4c950b_42fac34e;
            4'h3:    row = 128'h082ea166_28d924b2_765ba249_6d8bd125;
            4'h4:    row = 128'h72f8f664_86689816_d4a45ccc_5d65b692;
            4'h5:    row = 128'h6c704850_fdedb9da_5e154657_a78d9d84;
            4'h6:    row = 128'h90d8ab00_8cbcd30a_f7e45805_b8b34506;
            4'h7:    row = 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b;
            4'h8:    row = 128'h3a911141_4f67dcea_97f2cfce_f0b4e673;
            4'h9:    row = 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e;
            4'ha:    row = 128'h47f11a71_1d29c589_6fb7620e_aa18be1b;
            4'hb:    row = 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4;
            4'hc:    row = 128'h1fdda833_8807c731_b1121059_2780ec5f;
            4'hd:    row = 128'h60517fa9_19b54a0d_2de57a9f_93c99cef;
            4'he:    row = 128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961;
            default: row = 128'h172b047e_ba77d626_e1691463_55210c7d;
        endcase
        y_o = row[{~a_i[3:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/sbox.sv
// sbox: forward AES S-box, shared with the encrypt datapath and used here by
// the key schedule. Pure combinational lookup; each row constant holds the
// 16 outputs for one high nibble, leftmost byte = low nibble 0.
// Ports: a_i (byte in), y_o (substituted byte out).
module sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    logic [127:0] row;

    always_comb begin
        case (a_i[7:4])
            4'h0:    row = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
            4'h1:    row = 128'hca82c97d_fa5947f0_add4a2af_9ca472c0;
            4'h2:    row = 128'hb7fd9326_363ff7cc_34a5e5f1_71d83115;
            4'h3:    row = 128'h04c723c3_1896059a_071280e2_eb27b275;
            4'h4:    row = 128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84;
            4'h5:    row = 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf;
            4'h6:    row = 128'hd0efaafb_434d3385_45f9027f_503c9fa8;
            4'h7:    row = 128'h51a3408f_929d38f5_bcb6da21_10fff3d2;
            4'h8:    row = 128'hcd0c13ec_5f974417_c4a77e3d_645d1973;
            4'h9:    row = 128'h60814fdc_222a9088_46eeb814_de5e0bdb;
            4'ha:    row = 128'he0323a0a_4906245c_c2d3ac62_9195e479;
            4'hb:    row = 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08;
            4'hc:    row = 128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a;
            4'hd:    row = 128'h703eb566_4803f60e_613557b9_86c11d9e;
            4'he:    row = 128'he1f89811_69d98e94_9b1e87e9_ce5528df;
            default: row = 128'h8ca1890d_bfe64268_41992d0f_b054bb16;
        endcase
        // Byte n of the row sits at bit offset 8*(15-n); 15-n == ~n for 4 bits.
        y_o = row[{~a_i[3:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/aes128_decrypt_core.sv
// aes128_decrypt_core: iterative AES-128 inverse cipher, one round per clock.
// An accepted block first runs the forward key schedule for 10 cycles to
// reach the round-10 key, then walks the key schedule backwards while
// applying one inverse round per cycle. Output after 20 edges.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     ciphertext+key handshake (ready only when idle)
//   ciphertext, key       128-bit, byte 0 in bits [127:120]
//   out_valid/out_ready   plaintext handshake
//   plaintext             128-bit result, held until accepted
module aes128_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] pt_q, pt_d;
    logic [3:0]   cnt_q, cnt_d;   // KEXP: round-constant index 1..10; ROUND: r 9..0
    logic         out_valid_q, out_valid_d;

    // Key schedule: one set of 4 S-boxes serves both directions.
    logic [31:0]  w0, w1, w2, w3, w3_prev;
    logic [31:0]  sb_word, sb_in, sb_out, rcon_w;
    logic [3:0]   rcon_idx;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] k_fwd, k_inv;

    assign {w0, w1, w2, w3} = rk_q;
    // Last word of the previous round key, needed before w0 can be undone.
    assign w3_prev  = w3 ^ w2;
    assign sb_word  = (state_q == ROUND) ? w3_prev : w3;
    assign sb_in    = {sb_word[23:0], sb_word[31:24]};
    // Going backwards from k(r+1) needs the constant that produced it.
    assign rcon_idx = (state_q == ROUND) ? cnt_q + 4'd1 : cnt_q;
    assign rcon_w   = {rcon_byte(rcon_idx), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
        sbox u_sbox (
            .a_i (sb_in[8*i +: 8]),
            .y_o (sb_out[8*i +: 8])
        );
    end

    assign f0    = w0 ^ sb_out ^ rcon_w;
    assign f1    = w1 ^ f0;
    assign f2    = w2 ^ f1;
    assign f3    = w3 ^ f2;
    assign k_fwd = {f0, f1, f2, f3};
    assign k_inv = {w0 ^ sb_out ^ rcon_w, w1 ^ w0, w2 ^ w1, w3_prev};

    // Inverse round datapath.
    logic [127:0] isr, isb, ark, round_out;

    assign isr = inv_shift_rows(st_q);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (
            .a_i (isr[8*i +: 8]),
            .y_o (isb[8*i +: 8])
        );
    end

    assign ark       = isb ^ k_inv;
    // The final round (r == 0) has no InvMixColumns.
    assign round_out = (cnt_q == 4'd0) ? ark : inv_mix_columns(ark);

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        pt_d        = pt_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = ciphertext;
                    rk_d    = key;
                    cnt_d   = 4'd1;
                    state_d = KEXP;
                end
            end
            KEXP: begin
                rk_d  = k_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    // k_fwd is k10 here: fold in the initial AddRoundKey.
                    st_d    = st_q ^ k_fwd;
                    cnt_d   = 4'd9;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = round_out;
                rk_d  = k_inv;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    pt_d        = round_out;
                    out_valid_d = 1'b1;
                    // Scrub key and intermediate state once the result is out.
                    st_d        = '0;
                    rk_d        = '0;
                    cnt_d       = 4'd0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            pt_q        <= '0;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            pt_q        <= pt_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;

endmodule
